// File: rtl/button_pwm_ctrl.sv
// N-channel button debouncer with per-channel brightness level and glitch-free PWM LED drive.
// Optional BUTTON_PWM_GAMMA_EN squares the level (gamma 2) before it reaches the PWM compare.
module button_pwm_ctrl #(
    parameter int unsigned NCH             = 3,
    parameter int unsigned PWM_BITS        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned STEP            = 32,
    parameter int unsigned INIT_LEVEL      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          button_i,
    output logic [NCH-1:0]          press_o,
    output logic [NCH*PWM_BITS-1:0] level_o,
    output logic [NCH-1:0]          pwm_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SUM_W = PWM_BITS + 1;

    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] MAX_LEVEL = {PWM_BITS{1'b1}};
    localparam logic [SUM_W-1:0]    STEP_EXT  = SUM_W'(STEP);
    localparam logic [PWM_BITS-1:0] INIT      = PWM_BITS'(INIT_LEVEL);

    logic [NCH-1:0] sync0_q, sync1_q;
    logic [NCH-1:0] stable_q, stable_d;
    logic [NCH-1:0] press_q, press_d;
    logic [NCH-1:0] pwm_q, pwm_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    logic [NCH-1:0][PWM_BITS-1:0] level_q, level_d;
    logic [NCH-1:0][PWM_BITS-1:0] shadow_q, shadow_d;
    logic [NCH-1:0][PWM_BITS-1:0] duty;

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                period_end;

    assign period_end = (pwm_cnt_q == MAX_LEVEL);

    // Two-flop synchroniser; idle level is released (high) so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= '1;
            sync1_q <= '1;
        end else begin
            sync0_q <= button_i;
            sync1_q <= sync0_q;
        end
    end

    always_comb begin
        stable_d = stable_q;
        press_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (sync1_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync1_q[i];
                    // Only a released->pressed flip (stable was 1) generates a pulse.
                    press_d[i]  = stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '1;
            press_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    function automatic logic [PWM_BITS-1:0] step_level(input logic [PWM_BITS-1:0] lvl);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, lvl} + STEP_EXT;
        if (lvl == MAX_LEVEL) begin
            return '0;
        end else if (sum > {1'b0, MAX_LEVEL}) begin
            return MAX_LEVEL;
        end else begin
            return sum[PWM_BITS-1:0];
        end
    endfunction

    // Shadow only follows level at the period boundary, so a duty change never cuts a pulse.
    always_comb begin
        level_d  = level_q;
        shadow_d = shadow_q;
        for (int i = 0; i < NCH; i++) begin
            if (press_d[i]) begin
                level_d[i] = step_level(level_q[i]);
            end
            if (period_end) begin
                shadow_d[i] = level_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q  <= {NCH{INIT}};
            shadow_q <= {NCH{INIT}};
        end else begin
            level_q  <= level_d;
            shadow_q <= shadow_d;
        end
    end

`ifdef BUTTON_PWM_GAMMA_EN
    localparam int unsigned SQ_W = 2 * PWM_BITS;
    localparam logic [SQ_W-1:0]     INIT_SQ   = SQ_W'(INIT_LEVEL) * SQ_W'(INIT_LEVEL);
    localparam logic [PWM_BITS-1:0] INIT_DUTY = INIT_SQ[SQ_W-1:PWM_BITS];

    logic [NCH-1:0][PWM_BITS-1:0] duty_q, duty_d;

    function automatic logic [PWM_BITS-1:0] gamma2(input logic [PWM_BITS-1:0] lvl);
        logic [SQ_W-1:0] sq;
        sq = SQ_W'(lvl) * SQ_W'(lvl);
        return sq[SQ_W-1:PWM_BITS];
    endfunction

    // Loaded in lockstep with shadow so the squared duty is ready on the first count of a period.
    always_comb begin
        duty_d = duty_q;
        for (int i = 0; i < NCH; i++) begin
            if (period_end) begin
                duty_d[i] = gamma2(shadow_d[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= {NCH{INIT_DUTY}};
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty = duty_q;
`else
    assign duty = shadow_q;
`endif

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < NCH; i++) begin
            pwm_d[i] = (pwm_cnt_q < duty[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            pwm_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            pwm_q     <= pwm_d;
        end
    end

    assign press_o = press_q;
    assign level_o = level_q;
    assign pwm_o   = pwm_q;

endmodule

// File: tb/tb_button_pwm_ctrl.sv
// Scoreboard bench for button_pwm_ctrl: expected press events are queued by the stimulus and
// popped by a monitor whenever press_o fires; PWM duty is measured over whole periods.
module tb_button_pwm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  button = 3'b111;
    logic [2:0]  press_o;
    logic [11:0] level_o;
    logic [2:0]  pwm_o;

    typedef struct packed {
        logic [2:0]  mask;
        logic [11:0] level;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edges = 0;
    int   press_edge = -100;

    button_pwm_ctrl #(
        .NCH(3),
        .PWM_BITS(4),
        .DEBOUNCE_CYCLES(4),
        .STEP(4),
        .INIT_LEVEL(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .button_i(button),
        .press_o(press_o),
        .level_o(level_o),
        .pwm_o(pwm_o)
    );

    always #5 clk = ~clk;

    // Edges since reset release; equals the free-running PWM count between edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && press_o != 3'b000) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_press: got press_o=%b with nothing pending", press_o);
            end else begin
                e = sb.pop_front();
                checks += 2;
                if (press_o !== e.mask) begin
                    errors++;
                    $display("FAIL press_mask: got %b expected %b", press_o, e.mask);
                end
                if (level_o !== e.level) begin
                    errors++;
                    $display("FAIL press_level: got %h expected %h", level_o, e.level);
                end
                press_edge = edges;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb.size(), 0);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic count_high(input int ch, output int hi);
        hi = 0;
        repeat (16) begin
            @(negedge clk);
            hi += int'(pwm_o[ch]);
        end
    endtask

    task automatic do_press(input logic [2:0] mask, input logic [11:0] exp_level);
        int start;
        sb.push_back('{mask, exp_level});
        @(negedge clk);
        button = button & ~mask;
        start = edges;
        wait_drain("press_seen");
        chk("press_latency", press_edge - start, 6);
        button = 3'b111;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int hi, bad, n, start, a0, a1, b0, b1;
        logic [7:0] bounce;

        // Reset state, then idle with buttons released.
        repeat (3) @(negedge clk);
        chk("rst_press", int'(press_o), 0);
        chk("rst_pwm", int'(pwm_o), 0);
        chk("rst_level", int'(level_o), 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (press_o != 3'b000 || pwm_o != 3'b000 || level_o != 12'h000) bad++;
        end
        chk("idle_after_reset", bad, 0);

        // Clean press on ch0.
        do_press(3'b001, 12'h004);
        repeat (20) @(negedge clk);
        count_high(0, hi);
        chk("pwm0_duty4", hi, 4);

        // Bounce on ch1: low 3, high 1, low 3, high.
        bounce = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            button[1] = bounce[i];
        end
        repeat (12) @(negedge clk);
        chk("bounce_levels", int'(level_o), 12'h004);

        // Step, saturate, wrap on ch2.
        do_press(3'b100, 12'h404);
        do_press(3'b100, 12'h804);
        do_press(3'b100, 12'hC04);
        do_press(3'b100, 12'hF04);
        repeat (20) @(negedge clk);
        count_high(2, hi);
        chk("pwm2_duty15", hi, 15);
        do_press(3'b100, 12'h004);
        repeat (20) @(negedge clk);
        count_high(2, hi);
        chk("pwm2_duty0", hi, 0);

        // Simultaneous ch0+ch1 press landing while the PWM count is 5.
        n = 0;
        @(negedge clk);
        while (edges % 16 != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("phase_align", edges % 16, 0);
        sb.push_back('{3'b011, 12'h048});
        button = 3'b100;
        start = edges;
        repeat (6) @(negedge clk);
        a0 = 0; a1 = 0; b0 = 0; b1 = 0;
        for (int i = 0; i < 26; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 10) begin
                a0 += int'(pwm_o[0]);
                a1 += int'(pwm_o[1]);
            end else begin
                b0 += int'(pwm_o[0]);
                b1 += int'(pwm_o[1]);
            end
        end
        button = 3'b111;
        wait_drain("simul_press_seen");
        chk("simul_latency", press_edge - start, 6);
        chk("no_runt_ch0", a0, 0);
        chk("no_runt_ch1", a1, 0);
        chk("next_period_ch0", b0, 8);
        chk("next_period_ch1", b1, 4);
        repeat (10) @(negedge clk);

        // Reset pulse mid-debounce with ch0 held low throughout.
        @(negedge clk);
        button = 3'b110;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_level", int'(level_o), 0);
        chk("midrst_pwm", int'(pwm_o), 0);
        sb.push_back('{3'b001, 12'h004});
        rst_n = 1'b1;
        wait_drain("midrst_press_seen");
        chk("midrst_latency", press_edge, 6);
        repeat (20) @(negedge clk);
        count_high(0, hi);
        chk("midrst_pwm0_duty4", hi, 4);
        button = 3'b111;
        repeat (10) @(negedge clk);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
